// File: rtl/exanet_outport_arbiter.sv
// exanet_outport_arbiter
// Shares one crossbar output among N_IN AXI-Stream requesters. A winner is
// picked in IDLE (high-priority class first, round-robin within the class
// from one shared last_grant pointer). The winner owns the output until its
// TLAST beat completes.
//
// Handshake: a beat transfers on a cycle where m_tvalid and m_tready are
// both high. While BUSY, m_tvalid is the owner's s_tvalid and
// s_tready[owner] is m_tready, so the owner's handshake and the output
// handshake are the same event. In IDLE, and while ARESET is high, no
// s_tready and no m_tvalid are asserted.
//
// Optional build macro EXANET_OUTPORT_ARB_STATS_EN: when defined, 32-bit
// header/payload/footer beat counters are built and reported on stats.
// When undefined, stats is tied to zero and stats_clr is ignored.
// fsm_state exposes the raw state register (0 = IDLE, 1 = BUSY).
module exanet_outport_arbiter #(
  parameter int N_IN = 4,
  parameter int DW   = 128
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [N_IN-1:0]   s_tvalid,
  output logic [N_IN-1:0]   s_tready,
  input  logic [N_IN*DW-1:0] s_tdata,
  input  logic [N_IN*5-1:0] s_tdest,
  input  logic [N_IN-1:0]   s_tlast,
  input  logic [N_IN-1:0]   s_prio,
  output logic              m_tvalid,
  output logic [DW-1:0]     m_tdata,
  output logic [4:0]        m_tdest,
  output logic              m_tlast,
  output logic              m_prio,
  input  logic              m_tready,
  output logic [2:0]        grant_id,
  output logic              busy,
  input  logic              stats_clr,
  output logic [95:0]       stats,
  output logic [0:0]        fsm_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]          state;
  logic [2:0]          owner;
  logic [2:0]          last_grant;

  logic [N_IN-1:0]     prio_req;
  logic [N_IN-1:0]     cand;
  logic [2*N_IN-1:0]   cand_dbl;
  logic [2*N_IN-1:0]   cand_rot;
  logic [3:0]          rot_amt;
  logic [3:0]          rr_off;
  logic [3:0]          rr_sum;
  logic [2:0]          winner;

  logic                active;
  logic                sel_valid;
  logic [DW-1:0]       sel_data;
  logic [4:0]          sel_dest;
  logic                sel_last;
  logic                sel_prio;
  logic                hs;

  // Outputs are live only while a packet owns the port and reset is low.
  assign active    = (state == ST_BUSY) && !ARESET;
  assign busy      = active;
  assign grant_id  = owner;
  assign fsm_state = state;

  // Winner selection: restrict to the high-priority class when it is
  // non-empty, then take the first candidate at or after last_grant+1.
  // The candidate vector is doubled and shifted so the search always runs
  // from bit 0 upward; the offset is added back modulo N_IN.
  always_comb begin
    prio_req = s_tvalid & s_prio;
    cand     = (|prio_req) ? prio_req : s_tvalid;
    cand_dbl = {cand, cand};
    rot_amt  = {1'b0, last_grant} + 4'd1;
    cand_rot = cand_dbl >> rot_amt;
    rr_off   = 4'd0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (cand_rot[i]) rr_off = 4'(i);
    end
    rr_sum = rot_amt + rr_off;
    if (rr_sum >= 4'(N_IN)) rr_sum = rr_sum - 4'(N_IN);
    winner = rr_sum[2:0];
  end

  // Select the owner's stream; everything reads as zero when not active.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_dest  = '0;
    sel_last  = 1'b0;
    sel_prio  = 1'b0;
    s_tready  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (active && (owner == 3'(i))) begin
        sel_valid   = s_tvalid[i];
        sel_data    = s_tdata[i*DW +: DW];
        sel_dest    = s_tdest[i*5 +: 5];
        sel_last    = s_tlast[i];
        sel_prio    = s_prio[i];
        s_tready[i] = m_tready;
      end
    end
  end

  assign m_tvalid = sel_valid;
  assign m_tdata  = sel_data;
  assign m_tdest  = sel_dest;
  assign m_tlast  = sel_last;
  assign m_prio   = sel_prio;
  assign hs       = m_tvalid && m_tready;

  // Two-state ownership FSM; the grant is frozen until the TLAST beat.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      owner      <= 3'd0;
      last_grant <= 3'(N_IN - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|s_tvalid) begin
            owner <= winner;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (hs && m_tlast) begin
            state      <= ST_IDLE;
            last_grant <= owner;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef EXANET_OUTPORT_ARB_STATS_EN
  typedef struct packed {
    logic [31:0] hdr;
    logic [31:0] pld;
    logic [31:0] ftr;
  } counter_t;

  logic        hdr_seen;
  logic [31:0] hdr_cnt;
  logic [31:0] pld_cnt;
  logic [31:0] ftr_cnt;
  logic        hdr_beat;
  logic        pld_beat;
  logic        ftr_beat;
  counter_t    cnt_view;

  // First handshaked beat is the header, the TLAST beat is the footer,
  // anything between is payload; a one-beat packet is header and footer.
  assign hdr_beat = hs && !hdr_seen;
  assign ftr_beat = hs && m_tlast;
  assign pld_beat = hs && hdr_seen && !m_tlast;

  // Tracks whether the current packet's header beat has gone by.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      hdr_seen <= 1'b0;
    end else if (hs) begin
      hdr_seen <= !m_tlast;
    end
  end

  // Header beat counter; clear wins over a coincident increment.
  always_ff @(posedge ACLK) begin
    if (ARESET || stats_clr) hdr_cnt <= 32'd0;
    else if (hdr_beat)       hdr_cnt <= hdr_cnt + 32'd1;
  end

  // Payload beat counter; clear wins over a coincident increment.
  always_ff @(posedge ACLK) begin
    if (ARESET || stats_clr) pld_cnt <= 32'd0;
    else if (pld_beat)       pld_cnt <= pld_cnt + 32'd1;
  end

  // Footer beat counter; clear wins over a coincident increment.
  always_ff @(posedge ACLK) begin
    if (ARESET || stats_clr) ftr_cnt <= 32'd0;
    else if (ftr_beat)       ftr_cnt <= ftr_cnt + 32'd1;
  end

  assign cnt_view.hdr = hdr_cnt;
  assign cnt_view.pld = pld_cnt;
  assign cnt_view.ftr = ftr_cnt;
  assign stats        = cnt_view;
`else
  logic stats_clr_unused;
  assign stats_clr_unused = stats_clr;
  assign stats            = 96'h0;
`endif

endmodule

// File: tb/tb_exanet_outport_arbiter.sv
// tb_exanet_outport_arbiter
// Directed scenarios followed by randomized traffic. A behavioural model
// tracks ownership, the round-robin pointer and beat classification and
// predicts every output each cycle. Stats expectations depend on
// EXANET_OUTPORT_ARB_STATS_EN.
module tb_exanet_outport_arbiter;

  localparam int N_IN = 4;
  localparam int DW   = 128;
`ifdef EXANET_OUTPORT_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic               ACLK = 1'b0;
  logic               ARESET;
  logic [N_IN-1:0]    s_tvalid;
  logic [N_IN-1:0]    s_tready;
  logic [N_IN*DW-1:0] s_tdata;
  logic [N_IN*5-1:0]  s_tdest;
  logic [N_IN-1:0]    s_tlast;
  logic [N_IN-1:0]    s_prio;
  logic               m_tvalid;
  logic [DW-1:0]      m_tdata;
  logic [4:0]         m_tdest;
  logic               m_tlast;
  logic               m_prio;
  logic               m_tready;
  logic [2:0]         grant_id;
  logic               busy;
  logic               stats_clr;
  logic [95:0]        stats;
  logic [0:0]         fsm_state;

  always #5 ACLK = ~ACLK;

  exanet_outport_arbiter #(.N_IN(N_IN), .DW(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tdest(s_tdest), .s_tlast(s_tlast), .s_prio(s_prio),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tdest(m_tdest),
    .m_tlast(m_tlast), .m_prio(m_prio), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .stats_clr(stats_clr),
    .stats(stats), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [2:0]  grant_q[$];
  logic [2:0]  exp_q[$];
  bit          prev_busy = 1'b0;

  // reference model: who owns the port, rr pointer, packet progress, counts
  bit          md_busy;
  int          md_owner;
  int          md_last;
  bit          md_mid;
  logic [31:0] e_hdr, e_pld, e_ftr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] exp_stats();
    return STATS_ON ? {e_hdr, e_pld, e_ftr} : 96'h0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int i, input bit v, input bit p, input bit l);
    s_tvalid[i]          = v;
    s_prio[i]            = p;
    s_tlast[i]           = l;
    s_tdata[i*DW +: DW]  = {$urandom, $urandom, $urandom, $urandom};
    s_tdest[i*5 +: 5]    = 5'($urandom_range(0, 31));
  endtask

  task automatic idle_all();
    for (int i = 0; i < N_IN; i++) drive_req(i, 1'b0, 1'b0, 1'b0);
  endtask

  // One cycle: check outputs against the model, log grants, advance model.
  task automatic step();
    logic [N_IN-1:0] pool;
    logic [N_IN-1:0] exp_rdy;
    bit              found;
    bit              hs;
    int              c;
    #1;
    if (md_busy && !ARESET) begin
      exp_rdy = '0;
      exp_rdy[md_owner] = m_tready;
      check("m_tvalid", m_tvalid, s_tvalid[md_owner]);
      check("s_tready", s_tready, exp_rdy);
      check("grant_id", grant_id, md_owner);
      check("m_tdata",  m_tdata,  s_tdata[md_owner*DW +: DW]);
      check("m_tdest",  m_tdest,  s_tdest[md_owner*5 +: 5]);
      check("m_tlast",  m_tlast,  s_tlast[md_owner]);
      check("m_prio",   m_prio,   s_prio[md_owner]);
    end else begin
      check("idle_m_tvalid", m_tvalid, 1'b0);
      check("idle_s_tready", s_tready, '0);
    end
    check("busy",  busy,  md_busy && !ARESET);
    check("stats", stats, exp_stats());
    if (busy && !prev_busy) grant_q.push_back(grant_id);
    prev_busy = busy;

    if (ARESET) begin
      md_busy = 0; md_owner = 0; md_last = N_IN - 1; md_mid = 0;
      e_hdr = 0; e_pld = 0; e_ftr = 0;
    end else begin
      if (!md_busy) begin
        if (|s_tvalid) begin
          pool  = (|(s_tvalid & s_prio)) ? (s_tvalid & s_prio) : s_tvalid;
          found = 0;
          for (int k = 1; k <= N_IN; k++) begin
            c = (md_last + k) % N_IN;
            if (!found && pool[c]) begin
              md_owner = c;
              found    = 1;
            end
          end
          md_busy = 1;
        end
      end else begin
        hs = s_tvalid[md_owner] && m_tready;
        if (hs) begin
          if (!md_mid) e_hdr = e_hdr + 1;
          if (s_tlast[md_owner]) e_ftr = e_ftr + 1;
          if (md_mid && !s_tlast[md_owner]) e_pld = e_pld + 1;
          md_mid = 1;
          if (s_tlast[md_owner]) begin
            md_busy = 0;
            md_last = md_owner;
            md_mid  = 0;
          end
        end
      end
      if (stats_clr) begin
        e_hdr = 0; e_pld = 0; e_ftr = 0;
      end
    end
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic pulse_reset();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
  endtask

  task automatic check_grants(input string tag);
    check({tag, "_count"}, grant_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < grant_q.size(); i++)
      check(tag, grant_q[i], exp_q[i]);
    grant_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ARESET = 1'b1; m_tready = 1'b0; stats_clr = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tdest = '0; s_tlast = '0; s_prio = '0;
    md_busy = 0; md_owner = 0; md_last = N_IN - 1; md_mid = 0;
    e_hdr = 0; e_pld = 0; e_ftr = 0;
    @(negedge ACLK);
    step();
    step();
    ARESET = 1'b0;
    check("reset_grant_id", grant_id, 3'd0);
    check("reset_stats", stats, 96'h0);
    check("reset_busy", busy, 1'b0);

    // single requester, three beats
    grant_q.delete();
    m_tready = 1'b1;
    drive_req(2, 1, 0, 0); step();
    check("single_latency_busy", busy, 1'b1);
    check("single_latency_valid", m_tvalid, 1'b1);
    drive_req(2, 1, 0, 0); step();
    drive_req(2, 1, 0, 0); step();
    drive_req(2, 1, 0, 1); step();
    idle_all(); step();
    check("single_idle", busy, 1'b0);
    check("single_stats", stats, STATS_ON ? {32'd1, 32'd1, 32'd1} : 96'h0);
    exp_q = '{3'd2};
    check_grants("single_grant");

    // round robin among four continuously offering one-beat packets
    pulse_reset();
    grant_q.delete();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < N_IN; i++) drive_req(i, 1, 0, 1);
      step();
      step();
    end
    idle_all(); step();
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    check_grants("rr_order");

    // priority: 3 high wins, raising prio[1] mid-packet does not preempt
    pulse_reset();
    grant_q.delete();
    drive_req(0, 1, 0, 0); drive_req(1, 1, 0, 0); drive_req(3, 1, 1, 0);
    step();
    check("prio_first", grant_id, 3'd3);
    step();
    drive_req(1, 1, 1, 0); step();
    step();
    drive_req(3, 1, 1, 1); step();
    drive_req(3, 0, 0, 0); step();
    check("prio_next", grant_id, 3'd1);
    drive_req(1, 1, 1, 1); step();
    idle_all(); step();
    exp_q = '{3'd3, 3'd1};
    check_grants("prio_order");

    // backpressure: m_tready 1,0,0,1 over a two-beat packet from 1
    pulse_reset();
    drive_req(1, 1, 0, 0); step();
    m_tready = 1'b1; step();
    drive_req(1, 1, 0, 1);
    m_tready = 1'b0; step();
    step();
    m_tready = 1'b1; step();
    idle_all(); step();
    check("bp_stats", stats, STATS_ON ? {32'd1, 32'd0, 32'd1} : 96'h0);

    // reset after beat 2 of 5, then arbitration restarts at requester 0
    pulse_reset();
    grant_q.delete();
    drive_req(2, 1, 0, 0); step();
    step();
    step();
    pulse_reset();
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rdy", s_tready, '0);
    check("rst_mid_stats", stats, 96'h0);
    for (int i = 0; i < N_IN; i++) drive_req(i, 1, 0, 1);
    step();
    check("rst_mid_rr0", grant_id, 3'd0);
    step();
    idle_all(); step();
    exp_q = '{3'd2, 3'd0};
    check_grants("rst_mid_order");

`ifdef EXANET_OUTPORT_ARB_STATS_EN
    // counter wrap and clear
    force dut.hdr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.hdr_cnt;
    e_hdr = 32'hFFFF_FFFF;
    drive_req(0, 1, 0, 1); step();
    step();
    idle_all(); step();
    check("wrap_hdr", stats[95:64], 32'd0);
    check("wrap_ftr", stats[31:0], 32'd2);
    drive_req(1, 1, 0, 1); step();
    stats_clr = 1'b1; step();
    stats_clr = 1'b0;
    idle_all(); step();
    check("clr_coincident", stats, 96'h0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N_IN; i++)
        drive_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0);
      m_tready  = $urandom_range(0, 3) != 0;
      stats_clr = $urandom_range(0, 49) == 0;
      ARESET    = $urandom_range(0, 199) == 0;
      step();
    end
    ARESET = 1'b0; stats_clr = 1'b0;
    idle_all(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
